// File: rtl/mc_hs_controller.sv
// Multi-cycle MIPS-subset control FSM with req/ready memory handshake,
// bounded memory wait, trap state and cycle/retired-instruction counters.
module mc_hs_controller #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TRAP_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic [1:0]       RegDst,
    output logic             RegWrite,
    output logic             ExtOp,
    output logic             LuiOp,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             PCorData,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EX_R,
        S_EX_SH,
        S_EX_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_R,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_JR,
        S_TRAP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              run;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nx;
    logic [1:0]        cause_nx;
    logic              retire;
    logic              wait_hit;
    logic              timeout_trap;

    // run stays low through reset and the first edge after release, so every
    // control output (mem_req included) drops asynchronously with reset
    assign wait_hit     = (wait_cnt == WAIT_LAST);
    assign timeout_trap = wait_hit && (TRAP_EN != 0);

    // State, wait counter and trap cause registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            run        <= 1'b0;
            wait_cnt   <= '0;
            trap_cause <= 2'b00;
        end else begin
            state      <= state_nx;
            run        <= 1'b1;
            wait_cnt   <= wait_nx;
            trap_cause <= cause_nx;
        end
    end

    // Free-running cycle counter and retired-instruction counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and Moore control decode; FETCH write enables follow mem_ready
    always_comb begin
        state_nx    = state;
        wait_nx     = '0;
        cause_nx    = trap_cause;
        retire      = 1'b0;
        mem_req     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 2'b00;
        RegWrite    = 1'b0;
        ExtOp       = 1'b0;
        LuiOp       = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 4'b0000;
        PCSource    = 2'b00;
        PCorData    = 1'b0;
        trap        = 1'b0;

        if (run) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    if (mem_ready) begin
                        IRWrite  = 1'b1;
                        PCWrite  = 1'b1;
                        state_nx = S_DECODE;
                    end else if (timeout_trap) begin
                        state_nx = S_TRAP;
                        cause_nx = CAUSE_TIMEOUT;
                    end else begin
                        wait_nx = wait_hit ? wait_cnt : wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    ExtOp   = 1'b1;
                    case (opcode)
                        OP_RTYPE: begin
                            if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA) begin
                                state_nx = S_EX_SH;
                            end else if (funct == FN_JR || funct == FN_JALR) begin
                                state_nx = S_JR;
                            end else begin
                                state_nx = S_EX_R;
                            end
                        end
                        OP_LW, OP_SW:     state_nx = S_MEM_ADDR;
                        OP_BEQ:           state_nx = S_BRANCH;
                        OP_J, OP_JAL:     state_nx = S_JUMP;
                        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI:
                                          state_nx = S_EX_I;
                        default: begin
                            if (TRAP_EN != 0) begin
                                state_nx = S_TRAP;
                                cause_nx = CAUSE_ILLEGAL;
                            end else begin
                                state_nx = S_FETCH;
                            end
                        end
                    endcase
                end
                S_EX_R: begin
                    ALUSrcA  = 2'b01;
                    ALUOp    = 4'b0010;
                    state_nx = S_WB_R;
                end
                S_EX_SH: begin
                    ALUSrcA  = 2'b10;
                    ALUOp    = 4'b0010;
                    state_nx = S_WB_R;
                end
                S_EX_I: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    ExtOp   = (opcode != OP_ANDI);
                    LuiOp   = (opcode == OP_LUI);
                    case (opcode)
                        OP_ANDI:  ALUOp = 4'b0011;
                        OP_SLTI:  ALUOp = 4'b0100;
                        OP_SLTIU: ALUOp = 4'b0101;
                        default:  ALUOp = 4'b0000;
                    endcase
                    state_nx = S_WB_R;
                end
                S_WB_R: begin
                    RegWrite = 1'b1;
                    RegDst   = (opcode == OP_RTYPE) ? 2'b01 : 2'b00;
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end
                S_MEM_ADDR: begin
                    ALUSrcA  = 2'b01;
                    ALUSrcB  = 2'b10;
                    ExtOp    = 1'b1;
                    state_nx = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD, S_MEM_WR: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemRead  = (state == S_MEM_RD);
                    MemWrite = (state == S_MEM_WR);
                    if (mem_ready) begin
                        if (state == S_MEM_RD) begin
                            state_nx = S_WB_MEM;
                        end else begin
                            retire   = 1'b1;
                            state_nx = S_FETCH;
                        end
                    end else if (timeout_trap) begin
                        state_nx = S_TRAP;
                        cause_nx = CAUSE_TIMEOUT;
                    end else begin
                        wait_nx = wait_hit ? wait_cnt : wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA     = 2'b01;
                    ALUOp       = 4'b0001;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    retire      = 1'b1;
                    state_nx    = S_FETCH;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                    if (opcode == OP_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        PCorData = 1'b1;
                    end
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end
                S_JR: begin
                    PCWrite = 1'b1;
                    ALUSrcA = 2'b01;
                    if (funct == FN_JALR) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b01;
                        PCorData = 1'b1;
                    end
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end
                S_TRAP: begin
                    trap     = 1'b1;
                    state_nx = S_TRAP;
                end
                default: begin
                    state_nx = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_hs_controller.sv
// Directed self-checking bench for mc_hs_controller: one trapping instance
// (TIMEOUT=4) and one non-trapping instance share clock, reset and inputs.
module tb_mc_hs_controller;

    localparam int unsigned CW = 32;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;

    logic mem_req_a, PCWrite_a, PCWriteCond_a, IorD_a, MemWrite_a, MemRead_a, IRWrite_a;
    logic MemtoReg_a, RegWrite_a, ExtOp_a, LuiOp_a, PCorData_a, trap_a;
    logic [1:0] RegDst_a, ALUSrcA_a, ALUSrcB_a, PCSource_a, trap_cause_a;
    logic [3:0] ALUOp_a;
    logic [CW-1:0] cycle_cnt_a, instret_cnt_a;

    logic mem_req_b, PCWrite_b, PCWriteCond_b, IorD_b, MemWrite_b, MemRead_b, IRWrite_b;
    logic MemtoReg_b, RegWrite_b, ExtOp_b, LuiOp_b, PCorData_b, trap_b;
    logic [1:0] RegDst_b, ALUSrcA_b, ALUSrcB_b, PCSource_b, trap_cause_b;
    logic [3:0] ALUOp_b;
    logic [CW-1:0] cycle_cnt_b, instret_cnt_b;

    int checks;
    int failures;

    mc_hs_controller #(.TIMEOUT(4), .CNT_W(CW), .TRAP_EN(1)) u_a (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req_a), .PCWrite(PCWrite_a), .PCWriteCond(PCWriteCond_a), .IorD(IorD_a),
        .MemWrite(MemWrite_a), .MemRead(MemRead_a), .IRWrite(IRWrite_a), .MemtoReg(MemtoReg_a),
        .RegDst(RegDst_a), .RegWrite(RegWrite_a), .ExtOp(ExtOp_a), .LuiOp(LuiOp_a),
        .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a), .ALUOp(ALUOp_a), .PCSource(PCSource_a),
        .PCorData(PCorData_a), .trap(trap_a), .trap_cause(trap_cause_a),
        .cycle_cnt(cycle_cnt_a), .instret_cnt(instret_cnt_a)
    );

    mc_hs_controller #(.TIMEOUT(4), .CNT_W(CW), .TRAP_EN(0)) u_b (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req_b), .PCWrite(PCWrite_b), .PCWriteCond(PCWriteCond_b), .IorD(IorD_b),
        .MemWrite(MemWrite_b), .MemRead(MemRead_b), .IRWrite(IRWrite_b), .MemtoReg(MemtoReg_b),
        .RegDst(RegDst_b), .RegWrite(RegWrite_b), .ExtOp(ExtOp_b), .LuiOp(LuiOp_b),
        .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .ALUOp(ALUOp_b), .PCSource(PCSource_b),
        .PCorData(PCorData_b), .trap(trap_b), .trap_cause(trap_cause_b),
        .cycle_cnt(cycle_cnt_b), .instret_cnt(instret_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle just after the falling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h20;

        // reset held for three cycles
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req_a), 0);
        chk("rst_memread", 32'(MemRead_a), 0);
        chk("rst_alusrcb", 32'(ALUSrcB_a), 0);
        chk("rst_trap", 32'({trap_a, trap_cause_a}), 0);
        chk("rst_cycle", cycle_cnt_a, 0);
        reset = 1'b1;
        #1;
        chk("rel_mem_req", 32'(mem_req_a), 0);

        // add: FETCH, DECODE, EX_R, WB_R
        tick();
        chk("add_f_req", 32'({mem_req_a, MemRead_a, IRWrite_a, PCWrite_a, IorD_a}), 5'b11110);
        chk("add_f_srcb", 32'({ALUSrcA_a, ALUSrcB_a, ALUOp_a, PCSource_a}), 10'b00_01_0000_00);
        chk("cycle_first", cycle_cnt_a, 1);
        tick();
        chk("add_d", 32'({mem_req_a, ALUSrcA_a, ALUSrcB_a, ExtOp_a}), 6'b0_00_11_1);
        tick();
        chk("add_ex", 32'({ALUSrcA_a, ALUSrcB_a, ALUOp_a}), 8'b01_00_0010);
        tick();
        chk("add_wb", 32'({RegWrite_a, RegDst_a, MemtoReg_a}), 4'b1_01_0);
        chk("add_wb_inst", instret_cnt_a, 0);
        tick();
        chk("add_inst", instret_cnt_a, 1);
        chk("add_cycles", cycle_cnt_a, 5);
        chk("add_back_f", 32'(mem_req_a), 1);

        // lw with data ready after three wait cycles
        opcode = 6'h23;
        tick();
        tick();
        chk("lw_addr", 32'({ALUSrcA_a, ALUSrcB_a, ExtOp_a, ALUOp_a}), 9'b01_10_1_0000);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lw_wait", 32'({mem_req_a, IorD_a, MemRead_a, MemWrite_a, RegWrite_a}), 5'b11100);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        chk("lw_ready", 32'({mem_req_a, IorD_a, MemRead_a, MemtoReg_a}), 4'b1110);
        tick();
        chk("lw_wb", 32'({RegWrite_a, MemtoReg_a, RegDst_a, mem_req_a}), 5'b11_00_0);
        tick();
        chk("lw_inst", instret_cnt_a, 2);
        chk("lw_cycles", cycle_cnt_a, 13);

        // jal
        opcode = 6'h03;
        tick();
        tick();
        chk("jal_j", 32'({PCWrite_a, PCSource_a, RegDst_a, PCorData_a, RegWrite_a}), 7'b1_11_10_1_1);
        tick();
        chk("jal_f", 32'({mem_req_a, PCorData_a}), 2'b10);
        chk("jal_inst", instret_cnt_a, 3);

        // beq
        opcode = 6'h04;
        tick();
        tick();
        chk("beq_b", 32'({PCWriteCond_a, PCWrite_a, PCSource_a, ALUSrcA_a, ALUOp_a}), 10'b1_0_01_01_0001);
        tick();
        chk("beq_inst", instret_cnt_a, 4);

        // andi: zero extend, AND, rt destination
        opcode = 6'h0C;
        tick();
        tick();
        chk("andi_ex", 32'({ExtOp_a, LuiOp_a, ALUSrcA_a, ALUSrcB_a, ALUOp_a}), 10'b0_0_01_10_0011);
        tick();
        chk("andi_wb", 32'({RegWrite_a, RegDst_a}), 3'b1_00);
        tick();
        chk("andi_inst", instret_cnt_a, 5);

        // jalr
        opcode = 6'h00;
        funct  = 6'h09;
        tick();
        tick();
        chk("jalr", 32'({PCWrite_a, PCSource_a, ALUSrcA_a, ALUSrcB_a, RegDst_a, PCorData_a, RegWrite_a}),
            11'b1_00_01_00_01_1_1);
        tick();
        chk("jalr_inst", instret_cnt_a, 6);

        // illegal opcode: trap on one instance, NOP on the other
        opcode = 6'h3F;
        funct  = 6'h00;
        tick();
        tick();
        chk("ill_trap", 32'({trap_a, trap_cause_a, mem_req_a}), 4'b1_01_0);
        chk("ill_nop_b", 32'({trap_b, mem_req_b, trap_cause_b}), 4'b0_1_00);
        chk("ill_inst_a", instret_cnt_a, 6);
        chk("ill_inst_b", instret_cnt_b, 6);
        tick();
        chk("trap_hold", 32'({trap_a, trap_cause_a, PCWrite_a, RegWrite_a, IRWrite_a}), 6'b1_01_000);
        chk("trap_cycle", cycle_cnt_a, 29);

        // FETCH timeout with mem_ready held low
        reset = 1'b0;
        #1;
        chk("rst_trap_clr", 32'({trap_a, trap_cause_a}), 0);
        mem_ready = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h20;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_wait", 32'({mem_req_a, IRWrite_a, PCWrite_a, trap_a}), 4'b1000);
        end
        tick();
        chk("to_trap", 32'({trap_a, trap_cause_a, mem_req_a, IRWrite_a}), 5'b1_10_0_0);
        chk("to_inst", instret_cnt_a, 0);
        chk("to_b_wait", 32'({mem_req_b, trap_b, IRWrite_b}), 3'b100);
        tick();
        chk("to_b_still", 32'({mem_req_b, trap_b}), 2'b10);

        // reset mid-wait drops mem_req asynchronously
        #2;
        reset = 1'b0;
        #1;
        chk("async_req_b", 32'(mem_req_b), 0);
        chk("async_cnt_b", cycle_cnt_b, 0);
        chk("async_trap_a", 32'({trap_a, trap_cause_a}), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
